// File: rtl/spi_sample_framer.sv
// Buffers 16-bit sensor words in a small FIFO. On each frame tick it sends all of them as one
// byte-serial telemetry frame: SYNC0 SYNC1 SEQ LEN payload CHK.
module spi_sample_framer #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  SYNC0 = 8'hEB,
  parameter logic [7:0]  SYNC1 = 8'h90
) (
  input  logic        CLK_26,
  input  logic        RST,
  input  logic [15:0] SAMPLE_DATA,
  input  logic        SAMPLE_VALID,
  input  logic        FRAME_START,
  output logic [7:0]  TX_BYTE,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        OVERFLOW,
  output logic        BUSY
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSync0 = 3'd1;
  localparam logic [2:0] StSync1 = 3'd2;
  localparam logic [2:0] StSeq   = 3'd3;
  localparam logic [2:0] StLen   = 3'd4;
  localparam logic [2:0] StHi    = 3'd5;
  localparam logic [2:0] StLo    = 3'd6;
  localparam logic [2:0] StChk   = 3'd7;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, rem_q;
  logic [2:0]    state_q, state_d;
  logic [7:0]    seq_q, chk_q, len_q;
  logic          ovf_q;
  logic          full, push, drop, accept, pop, start;
  logic [15:0]   rd_word;

  assign full    = (count_q == CW'(DEPTH));
  assign push    = SAMPLE_VALID & ~full;
  assign drop    = SAMPLE_VALID & full;
  assign accept  = TX_VALID & TX_READY;
  assign pop     = accept & (state_q == StLo);
  assign start   = (state_q == StIdle) & FRAME_START;
  assign rd_word = mem_q[rd_ptr_q];

  assign TX_VALID = (state_q != StIdle);
  assign BUSY     = (state_q != StIdle);
  assign OVERFLOW = ovf_q;

  // Output byte is decoded from registered state only, so it holds while stalled.
  always_comb begin
    TX_BYTE = 8'h00;
    case (state_q)
      StSync0: TX_BYTE = SYNC0;
      StSync1: TX_BYTE = SYNC1;
      StSeq:   TX_BYTE = seq_q;
      StLen:   TX_BYTE = len_q;
      StHi:    TX_BYTE = rd_word[15:8];
      StLo:    TX_BYTE = rd_word[7:0];
      StChk:   TX_BYTE = chk_q;
      default: TX_BYTE = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StSync0;
    end else if (accept) begin
      case (state_q)
        StSync0: state_d = StSync1;
        StSync1: state_d = StSeq;
        StSeq:   state_d = StLen;
        StLen:   state_d = (rem_q == '0) ? StChk : StHi;
        StHi:    state_d = StLo;
        StLo:    state_d = (rem_q == CW'(1)) ? StChk : StHi;
        StChk:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK_26) begin
    if (push) mem_q[wr_ptr_q] <= SAMPLE_DATA;
  end

  always_ff @(posedge CLK_26 or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      seq_q    <= 8'h00;
      chk_q    <= 8'h00;
      len_q    <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (start) begin
        rem_q <= count_q;
        chk_q <= 8'h00;
      end else if (accept) begin
        if (state_q inside {StSeq, StLen, StHi, StLo}) chk_q <= chk_q ^ TX_BYTE;
        if (pop) rem_q <= rem_q - CW'(1);
        if (state_q == StChk) seq_q <= seq_q + 8'd1;
      end
      // LEN is frozen when SEQ is accepted; only a reported overflow is cleared by it.
      if (accept && state_q == StSeq) len_q <= {ovf_q, 7'(rem_q)};
      ovf_q <= drop | (ovf_q & ~(accept & (state_q == StLen) & len_q[7]));
    end
  end

endmodule

// File: tb/tb_spi_sample_framer.sv
// Scoreboard bench for spi_sample_framer: stimulus queues expected frame bytes, a negedge
// monitor pops and compares every accepted byte and checks stall stability.
module tb_spi_sample_framer;

  logic        CLK_26 = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] SAMPLE_DATA = 16'h0000;
  logic        SAMPLE_VALID = 1'b0;
  logic        FRAME_START = 1'b0;
  logic [7:0]  TX_BYTE;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic        OVERFLOW;
  logic        BUSY;

  spi_sample_framer #(.DEPTH(16), .SYNC0(8'hEB), .SYNC1(8'h90)) dut (
    .CLK_26      (CLK_26),
    .RST         (RST),
    .SAMPLE_DATA (SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID),
    .FRAME_START (FRAME_START),
    .TX_BYTE     (TX_BYTE),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .OVERFLOW    (OVERFLOW),
    .BUSY        (BUSY)
  );

  always #19 CLK_26 = ~CLK_26;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] mq[$];
  logic [7:0]  seq_m = 8'h00;
  logic        ovf_m = 1'b0;
  bit          rnd = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  held = 8'h00;
  logic [7:0]  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_26);
    #1;
    TX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic write_sample(input logic [15:0] d);
    if (mq.size() < 16) mq.push_back(d);
    else ovf_m = 1'b1;
    SAMPLE_DATA  = d;
    SAMPLE_VALID = 1'b1;
    tick();
    SAMPLE_VALID = 1'b0;
  endtask

  // mid: iteration at which a sample + ignored tick are injected; abort: iteration for reset.
  task automatic issue_frame(input int mid, input logic [15:0] mid_word, input int abort);
    int         n;
    int         k;
    logic [7:0] len;
    logic [7:0] chk;
    logic [15:0] w;
    n   = mq.size();
    len = {ovf_m, 7'(n)};
    exp_q.push_back(8'hEB);
    exp_q.push_back(8'h90);
    exp_q.push_back(seq_m);
    exp_q.push_back(len);
    chk = seq_m ^ len;
    for (int i = 0; i < n; i++) begin
      w = mq.pop_front();
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      chk = chk ^ w[15:8] ^ w[7:0];
    end
    exp_q.push_back(chk);
    seq_m = seq_m + 8'd1;
    ovf_m = 1'b0;
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    k = 0;
    while (BUSY && k < 300) begin
      if (k == abort) begin
        RST = 1'b0;
        #1;
        check("reset_tx_valid", TX_VALID, 0);
        check("reset_busy", BUSY, 0);
        check("reset_tx_byte", TX_BYTE, 0);
        exp_q.delete();
        mq.delete();
        seq_m = 8'h00;
        ovf_m = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        break;
      end
      if (k == mid) begin
        SAMPLE_DATA  = mid_word;
        SAMPLE_VALID = 1'b1;
        FRAME_START  = 1'b1;
        mq.push_back(mid_word);
      end
      tick();
      SAMPLE_VALID = 1'b0;
      FRAME_START  = 1'b0;
      k++;
    end
    check("frame_timeout_busy", BUSY, 0);
    check("frame_drained", exp_q.size(), 0);
  endtask

  always @(negedge CLK_26) begin
    if (!RST) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (!(TX_VALID && TX_BYTE == held)) begin
          errors++;
          $display("FAIL hold: valid %0b byte %0h expected byte %0h", TX_VALID, TX_BYTE, held);
        end
      end
      stall = 1'b0;
      if (TX_VALID && TX_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", TX_BYTE);
        end else begin
          mon_e = exp_q.pop_front();
          if (TX_BYTE !== mon_e) begin
            errors++;
            $display("FAIL tx_byte: got %0h expected %0h", TX_BYTE, mon_e);
          end
        end
      end else if (TX_VALID) begin
        stall = 1'b1;
        held  = TX_BYTE;
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK_26);
    #1;
    check("rst_tx_byte", TX_BYTE, 0);
    check("rst_tx_valid", TX_VALID, 0);
    check("rst_overflow", OVERFLOW, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b1;
    tick();

    // 1: two words -> EB 90 00 02 12 34 AB CD 42
    write_sample(16'h1234);
    write_sample(16'hABCD);
    issue_frame(-1, 16'h0, -1);

    // 2: empty frame -> EB 90 01 00 01
    tick();
    issue_frame(-1, 16'h0, -1);

    // 3: overflow after 17 writes, LEN = 90
    for (int i = 0; i < 17; i++) write_sample(16'h1000 + 16'(i * 16'h0111));
    check("overflow_set", OVERFLOW, 1);
    issue_frame(-1, 16'h0, -1);
    check("overflow_cleared", OVERFLOW, 0);

    // 4: random ready throttling on a 4-word frame
    write_sample(16'hDEAD);
    write_sample(16'hBEEF);
    write_sample(16'h0F0F);
    write_sample(16'h8001);
    rnd = 1'b1;
    issue_frame(-1, 16'h0, -1);
    rnd = 1'b0;
    tick();

    // 5: mid-frame sample and ignored tick; word shows up in the next frame
    write_sample(16'h1111);
    write_sample(16'h2222);
    issue_frame(6, 16'h5A5A, -1);
    tick();
    issue_frame(-1, 16'h0, -1);

    // 6: reset during payload, then SEQ restarts at 00 and wraps after 256 frames
    write_sample(16'h3333);
    write_sample(16'h4444);
    write_sample(16'h5555);
    issue_frame(-1, 16'h0, 4);
    tick();
    issue_frame(-1, 16'h0, -1);
    for (int i = 0; i < 256; i++) begin
      tick();
      issue_frame(-1, 16'h0, -1);
    end
    check("final_overflow", OVERFLOW, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
